module_timer_bombillos: RTL and testbench
=========================================

Name: module_timer_bombillos

Overview:
- Timeout timer at the far end of the lobby-light control FSM's timer handshake.
- Consumes the FSM enable (en_i) and returns a one-cycle completion pulse (fin_o) after a programmable number of prescaled ticks.
- Aborts silently when the enable drops, so the controller's room transitions never see a stale fin.
- Sits beside the light-control FSM in the apartment light top level.

Parameters:
PRESCALE, 10_000_000, clk cycles per timer tick (1 s at 10 MHz); must be >= 2
TIMEOUT_W, 8, width of timeout_i / remaining_o
WARN_TICKS, 5, ticks before expiry at which warn_o asserts (optional feature only)

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous, active-low reset
en_i  in  1  run request from light-control FSM; level, high while lobby timer should run
timeout_i  in  TIMEOUT_W  timeout in ticks; sampled only on IDLE->RUN/DONE transition
fin_o  out  1  registered one-cycle pulse: timeout expired
busy_o  out  1  high while in RUN
remaining_o  out  TIMEOUT_W  ticks left; 0 when not RUN
warn_o  out  1  pre-expiry warning (exists only with TIMER_WARN_EN)

Behaviour:
- Reset (rst_i low, async): state IDLE, prescaler 0, remaining 0, fin_o/busy_o/warn_o 0, remaining_o 0. Reset mid-run discards the run; no fin.
- States: IDLE, RUN, DONE (registered, encoding from package).
- IDLE: en_i=1 at edge k and timeout_i!=0 -> RUN at edge k; remaining<=timeout_i, prescaler<=0. en_i=1 with timeout_i=0 -> DONE at edge k, fin_o=1 from edge k. en_i=0 -> stay.
- RUN: prescaler counts 0..PRESCALE-1 and wraps; tick = (prescaler==PRESCALE-1). On tick, remaining decrements. Tick with remaining==1 -> DONE, fin_o=1, remaining 0.
- fin_o rises exactly at edge k + timeout_i*PRESCALE. Stays high exactly one cycle.
- RUN with en_i=0 at any edge -> IDLE, prescaler/remaining cleared, no fin. Abort wins over a simultaneous terminal tick.
- DONE: fin_o cleared on next edge. Hold in DONE while en_i=1; no retrigger. en_i=0 -> IDLE. A new run needs en_i low for >=1 edge.
- timeout_i changes during RUN are ignored.
- busy_o = (state==RUN). remaining_o registered, mirrors remaining.
- Widths: remaining is TIMEOUT_W bits unsigned, never underflows. Prescaler width is $clog2(PRESCALE).

Optional Feature:
- Macro TIMER_WARN_EN.
- Defined: warn_o port exists. warn_o=1 while state==RUN and remaining<=WARN_TICKS (registered with remaining; drives lobby-light blink). warn_o=0 in IDLE/DONE and on abort.
- Undefined: no warn_o port and no compare logic; all other behaviour identical.

Decomposition:
- Package pkg_timer_bombillos: state enum (IDLE, RUN, DONE), DEFAULT_PRESCALE, DEFAULT_TIMEOUT=30.
- Sub-module module_prescaler_tick: PRESCALE param; ports clk_i, rst_i, clr_i, tick_o. Synchronous clear on RUN entry and abort.

Test Plan (PRESCALE=4, TIMEOUT_W=8, WARN_TICKS=1):
- Reset asserted mid-RUN (remaining=2) -> all outputs 0 immediately, before any clock edge; no fin after release with en_i=0.
- en_i=1 sampled at edge 1, timeout_i=3 -> busy_o=1 from edge 1; remaining_o 3,2,1 stepping at edges 5,9; fin_o=1 only in cycle after edge 13; busy_o=0 from edge 13.
- en_i held high 20 cycles after fin -> no second fin_o; en_i low 1 cycle, then high again -> new run, fin 12 cycles later.
- en_i drops at edge 13 (same edge as terminal tick) -> IDLE, fin_o never asserts, remaining_o=0.
- timeout_i=0 with en_i=1 at edge 2 -> fin_o=1 for the cycle after edge 2 only; busy_o stays 0.
- TIMER_WARN_EN, timeout_i=3 -> warn_o=1 from edge 9 (remaining=1) to edge 13; 0 otherwise; 0 immediately on abort.

Source files
------------

// File: rtl/module_timer_bombillos_pkg.sv
// Shared types and defaults for the lobby-light timeout timer.
package pkg_timer_bombillos;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_PRESCALE = 10_000_000;
    localparam int unsigned DEFAULT_TIMEOUT  = 30;

endpackage

// File: rtl/module_timer_bombillos_if.sv
// Timer handshake between the light-control FSM (master) and the timer (slave).
// warn_o exists only when TIMER_WARN_EN is defined.
interface module_timer_bombillos_if #(
    parameter int unsigned TIMEOUT_W = 8
);
    logic                 en_i;
    logic [TIMEOUT_W-1:0] timeout_i;
    logic                 fin_o;
    logic                 busy_o;
    logic [TIMEOUT_W-1:0] remaining_o;
`ifdef TIMER_WARN_EN
    logic                 warn_o;

    modport master (output en_i, timeout_i, input fin_o, busy_o, remaining_o, warn_o);
    modport slave  (input en_i, timeout_i, output fin_o, busy_o, remaining_o, warn_o);
`else
    modport master (output en_i, timeout_i, input fin_o, busy_o, remaining_o);
    modport slave  (input en_i, timeout_i, output fin_o, busy_o, remaining_o);
`endif
endinterface

// File: rtl/module_timer_bombillos_prescaler.sv
// Free-running modulo-PRESCALE counter with synchronous clear; tick_o flags the last count.
module module_prescaler_tick #(
    parameter int unsigned PRESCALE = 10_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam int unsigned     CNT_W = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/module_timer_bombillos.sv
// Lobby-light timeout timer: counts timeout_i prescaled ticks while en_i is high, then pulses fin_o.
// Optional warn_o (pre-expiry blink) is built only when TIMER_WARN_EN is defined.
module module_timer_bombillos
    import pkg_timer_bombillos::*;
#(
    parameter int unsigned PRESCALE   = DEFAULT_PRESCALE,
    parameter int unsigned TIMEOUT_W  = 8,
    parameter int unsigned WARN_TICKS = 5
) (
    input logic                    clk_i,
    input logic                    rst_i,
    module_timer_bombillos_if.slave bus
);
    if (PRESCALE < 2) begin : g_bad_prescale
        $error("PRESCALE must be >= 2");
    end
    if (WARN_TICKS >= (64'd1 << TIMEOUT_W)) begin : g_bad_warn
        $error("WARN_TICKS does not fit in TIMEOUT_W bits");
    end

    state_e               state_q, state_d;
    logic [TIMEOUT_W-1:0] rem_q, rem_d;
    logic                 fin_q, fin_d;
    logic                 tick;
    logic                 clr;

    // Prescaler is held at zero outside RUN, so RUN entry and abort both restart it.
    assign clr = (state_q != RUN) || !bus.en_i;

    module_prescaler_tick #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clr),
        .tick_o(tick)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        fin_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.en_i) begin
                    if (bus.timeout_i == '0) begin
                        state_d = DONE;
                        fin_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                        rem_d   = bus.timeout_i;
                    end
                end
            end
            RUN: begin
                // Abort takes priority over a terminal tick on the same edge.
                if (!bus.en_i) begin
                    state_d = IDLE;
                    rem_d   = '0;
                end else if (tick) begin
                    if (rem_q == TIMEOUT_W'(1)) begin
                        state_d = DONE;
                        rem_d   = '0;
                        fin_d   = 1'b1;
                    end else begin
                        rem_d = rem_q - TIMEOUT_W'(1);
                    end
                end
            end
            DONE: begin
                if (!bus.en_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                rem_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            rem_q   <= '0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            fin_q   <= fin_d;
        end
    end

    assign bus.fin_o       = fin_q;
    assign bus.busy_o      = (state_q == RUN);
    assign bus.remaining_o = rem_q;

`ifdef TIMER_WARN_EN
    logic warn_q, warn_d;

    assign warn_d = (state_d == RUN) && (rem_d <= TIMEOUT_W'(WARN_TICKS));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            warn_q <= 1'b0;
        end else begin
            warn_q <= warn_d;
        end
    end

    assign bus.warn_o = warn_q;
`endif

endmodule

// File: tb/tb_module_timer_bombillos.sv
// Directed bench for module_timer_bombillos with an elapsed-time reference model checked every cycle.
module tb_module_timer_bombillos;

    localparam int P  = 4;
    localparam int W  = 8;
    localparam int WT = 1;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    module_timer_bombillos_if #(.TIMEOUT_W(W)) bus ();

    module_timer_bombillos #(
        .PRESCALE  (P),
        .TIMEOUT_W (W),
        .WARN_TICKS(WT)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    int tests  = 0;
    int fails  = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: a run started at edge 'start' with timeout T finishes at edge start+T*P;
    // remaining is T minus whole ticks elapsed.
    int ecnt  = 0;
    int start = 0;
    int tmo   = 0;
    bit m_run = 1'b0;
    bit m_done = 1'b0;
    bit m_fin = 1'b0;

    initial begin
        forever begin
            @(posedge clk_i or negedge rst_i);
            if (!rst_i) begin
                m_run  = 1'b0;
                m_done = 1'b0;
                m_fin  = 1'b0;
                ecnt   = 0;
            end else begin
                ecnt++;
                m_fin = 1'b0;
                if (m_run) begin
                    if (!bus.en_i) begin
                        m_run = 1'b0;
                    end else if (ecnt - start == tmo * P) begin
                        m_run  = 1'b0;
                        m_done = 1'b1;
                        m_fin  = 1'b1;
                    end
                end else if (m_done) begin
                    if (!bus.en_i) m_done = 1'b0;
                end else if (bus.en_i) begin
                    if (bus.timeout_i == 0) begin
                        m_done = 1'b1;
                        m_fin  = 1'b1;
                    end else begin
                        m_run = 1'b1;
                        start = ecnt;
                        tmo   = int'(bus.timeout_i);
                    end
                end
            end
        end
    end

    function automatic int exp_rem();
        return m_run ? tmo - (ecnt - start) / P : 0;
    endfunction

    initial begin
        forever begin
            @(negedge clk_i);
            if (cmp_en) begin
                check("model_fin",  32'(bus.fin_o),       32'(m_fin));
                check("model_busy", 32'(bus.busy_o),      32'(m_run));
                check("model_rem",  32'(bus.remaining_o), 32'(exp_rem()));
`ifdef TIMER_WARN_EN
                check("model_warn", 32'(bus.warn_o), 32'(m_run && (exp_rem() <= WT)));
`endif
            end
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        bus.en_i      = 1'b0;
        bus.timeout_i = '0;
        #2;
        check("reset_fin",  32'(bus.fin_o),       0);
        check("reset_busy", 32'(bus.busy_o),      0);
        check("reset_rem",  32'(bus.remaining_o), 0);
        cmp_en = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b1;

        // Basic run, timeout 3: start edge k
        edges(1);
        bus.en_i = 1'b1;
        bus.timeout_i = 8'd3;
        edges(1);
        check("run_busy_k", 32'(bus.busy_o), 1);
        check("run_rem_k",  32'(bus.remaining_o), 3);
        bus.timeout_i = 8'd7;
        edges(4);
        check("run_rem_k4", 32'(bus.remaining_o), 2);
        edges(4);
        check("run_rem_k8", 32'(bus.remaining_o), 1);
`ifdef TIMER_WARN_EN
        check("warn_k8", 32'(bus.warn_o), 1);
`endif
        edges(3);
        check("run_fin_k11", 32'(bus.fin_o), 0);
        edges(1);
        check("run_fin_k12",  32'(bus.fin_o),  1);
        check("run_busy_k12", 32'(bus.busy_o), 0);
        check("run_rem_k12",  32'(bus.remaining_o), 0);
`ifdef TIMER_WARN_EN
        check("warn_k12", 32'(bus.warn_o), 0);
`endif
        edges(1);
        check("run_fin_k13", 32'(bus.fin_o), 0);

        // Hold in DONE, then retrigger after one low edge
        edges(20);
        check("hold_nofin", 32'(bus.fin_o), 0);
        bus.en_i = 1'b0;
        edges(1);
        bus.en_i = 1'b1;
        bus.timeout_i = 8'd3;
        edges(12);
        check("retrig_fin_early", 32'(bus.fin_o), 0);
        edges(1);
        check("retrig_fin", 32'(bus.fin_o), 1);
        bus.en_i = 1'b0;
        edges(2);

        // Abort on the terminal-tick edge
        bus.en_i = 1'b1;
        edges(1);
        edges(11);
`ifdef TIMER_WARN_EN
        check("warn_pre_abort", 32'(bus.warn_o), 1);
`endif
        bus.en_i = 1'b0;
        edges(1);
        check("abort_fin",  32'(bus.fin_o),  0);
        check("abort_busy", 32'(bus.busy_o), 0);
        check("abort_rem",  32'(bus.remaining_o), 0);
`ifdef TIMER_WARN_EN
        check("abort_warn", 32'(bus.warn_o), 0);
`endif
        edges(1);
        check("abort_fin_after", 32'(bus.fin_o), 0);

        // Zero timeout: immediate one-cycle fin
        bus.en_i = 1'b1;
        bus.timeout_i = 8'd0;
        edges(1);
        check("zero_fin",  32'(bus.fin_o),  1);
        check("zero_busy", 32'(bus.busy_o), 0);
        edges(1);
        check("zero_fin_clr", 32'(bus.fin_o), 0);
        bus.en_i = 1'b0;
        edges(1);

        // Asynchronous reset mid-run with remaining 2
        bus.en_i = 1'b1;
        bus.timeout_i = 8'd3;
        edges(1);
        edges(4);
        check("pre_rst_rem", 32'(bus.remaining_o), 2);
        #2;
        rst_i = 1'b0;
        #1;
        check("rst_mid_fin",  32'(bus.fin_o),  0);
        check("rst_mid_busy", 32'(bus.busy_o), 0);
        check("rst_mid_rem",  32'(bus.remaining_o), 0);
`ifdef TIMER_WARN_EN
        check("rst_mid_warn", 32'(bus.warn_o), 0);
`endif
        bus.en_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        edges(20);
        check("post_rst_fin",  32'(bus.fin_o),  0);
        check("post_rst_busy", 32'(bus.busy_o), 0);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
